a1_requant_pack: RTL
====================

A1_REQUANT_PACK -- requirements
Module: a1_requant_pack

Downstream of decompose_L1: rounds and saturates the 8-lane 48-bit a1 approximation word to 16 bits. Packs two consecutive a1 words into one 16-lane word in the format decompose_L1 accepts, feeding the next decomposition level.

Interface
REQ-001 Parameter DATA_WIDTH, default 16: output sample width.
REQ-002 Parameter INTERNAL_WIDTH, default 48: input sample width.
REQ-003 Parameter SHIFT, default 23: fractional bits removed (Q23 coefficient scaling).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 din_valid  input  1  a1_0..a1_7 carry a valid word this cycle.
REQ-007 a1_0..a1_7  input  INTERNAL_WIDTH each, signed  a1 lanes; lane 0 is earliest in time.
REQ-008 sync_clr  input  1  synchronous clear of pairing phase, pipeline and sticky flag.
REQ-009 dout_valid  output  1  one-cycle pulse when dout_0..dout_15 carry a new packed word.
REQ-010 dout_0..dout_15  output  DATA_WIDTH each, signed  packed samples; lane 0 is earliest in time.
REQ-011 sat_flag  output  1  sticky: at least one sample saturated since reset or sync_clr.

Function
REQ-012 Stage 1 (registered) SHALL compute q = floor((a1 + 2^(SHIFT-1)) / 2^SHIFT) per lane, i.e. round half toward +inf.
REQ-013 The stage-1 rounding addition SHALL be performed at INTERNAL_WIDTH+1 bits, with no wrap.
REQ-014 Stage 1 SHALL saturate q to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] = [-32768, 32767].
REQ-015 Stage 1 SHALL set sat_flag on the cycle after any lane of a valid word saturates.
REQ-016 sat_flag SHALL stay set until reset or sync_clr.
REQ-017 Stage 1 SHALL carry a valid bit, v1, equal to din_valid delayed one cycle.
REQ-018 Pairing phase register ph (states EVEN, ODD) SHALL be EVEN after reset.
REQ-019 v1 in EVEN: store the stage-1 word in the low buffer; go to ODD; dout_valid stays 0.
REQ-020 v1 in ODD: register dout_0..7 = low buffer and dout_8..15 = current stage-1 word; pulse dout_valid=1 for one cycle; go to EVEN.
REQ-021 Latency: dout_valid SHALL rise exactly 2 cycles after the din_valid cycle of the second word of a pair.
REQ-022 Throughput: one input word per cycle, sustained; one output word every 2 input words.
REQ-023 din_valid gaps of any length SHALL NOT change ph or the low buffer; pairing resumes with the next valid word.
REQ-024 Between pulses, dout_0..15 SHALL hold their last value.
REQ-025 sync_clr=1 SHALL force ph=EVEN, clear v1 and sat_flag, and force dout_valid=0 on the next cycle.
REQ-026 sync_clr has priority over din_valid: a word presented in the same cycle is discarded, and so is any word then in stage 1.
REQ-027 sync_clr SHALL NOT change the dout data registers.

Reset
REQ-028 rst_n=0 SHALL immediately force ph=EVEN, v1=0, dout_valid=0, sat_flag=0 and dout_0..15=0, independent of clk.
REQ-029 The low buffer SHALL reset to 0.
REQ-030 Reset applied mid-pair SHALL discard the half-pair.
REQ-031 The first valid word after reset release SHALL be treated as EVEN.

Verification
REQ-032 All lanes a1=0x000000800000, then all lanes 0x000001000000, back-to-back -> one dout_valid pulse 2 cycles after the second word; dout_0..7=1, dout_8..15=2; sat_flag=0.
REQ-033 Rounding, lanes 0..3 of a1 = 0x400000, 0xFFFFFFC00000, 0x3FFFFF, 0xFFFFFF400000 -> dout 1, 0, 0, -1 respectively.
REQ-034 Saturation, lane 0 = 2^38 and lane 1 = -2^38 -> dout 32767 and -32768; sat_flag=1 from the next cycle until sync_clr.
REQ-035 Gap, word A, din_valid=0 for 3 cycles, word B -> single pulse 2 cycles after B with A in lanes 0..7; no pulse during the gap.
REQ-036 sync_clr asserted between A and B, then C -> B pairs with C (B in lanes 0..7); A never appears; dout_valid=0 while sync_clr is high.
REQ-037 rst_n pulsed low mid-pair -> all outputs 0 asynchronously; the next two words form the first pair.

Source files
------------

// File: rtl/a1_requant_pack.sv
`default_nettype none
// ============================================================================
//  Module      : a1_requant_pack
//  Description : Rounds (half toward +inf) and saturates each lane of an
//                8-lane INTERNAL_WIDTH a1 approximation word down to
//                DATA_WIDTH bits. It then packs two consecutive words into
//                one 16-lane word for the next decomposition level.
//  Ports       : clk, rst_n       - clock, async active-low reset
//                din_valid        - a1_0..a1_7 hold a valid word
//                a1_0..a1_7       - signed input lanes (lane 0 earliest)
//                sync_clr         - sync clear of phase, pipeline, sticky flag
//                dout_valid       - one-cycle pulse, new packed word
//                dout_0..dout_15  - signed packed lanes (lane 0 earliest)
//                sat_flag         - sticky saturation indicator
//  Revision    : 1.0 - initial release
// ============================================================================
module a1_requant_pack #(
   parameter int DATA_WIDTH     = 16,
   parameter int INTERNAL_WIDTH = 48,
   parameter int SHIFT          = 23
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             din_valid,
   input  logic signed [INTERNAL_WIDTH-1:0] a1_0,
   input  logic signed [INTERNAL_WIDTH-1:0] a1_1,
   input  logic signed [INTERNAL_WIDTH-1:0] a1_2,
   input  logic signed [INTERNAL_WIDTH-1:0] a1_3,
   input  logic signed [INTERNAL_WIDTH-1:0] a1_4,
   input  logic signed [INTERNAL_WIDTH-1:0] a1_5,
   input  logic signed [INTERNAL_WIDTH-1:0] a1_6,
   input  logic signed [INTERNAL_WIDTH-1:0] a1_7,
   input  logic                             sync_clr,
   output logic                             dout_valid,
   output logic signed [DATA_WIDTH-1:0]     dout_0,
   output logic signed [DATA_WIDTH-1:0]     dout_1,
   output logic signed [DATA_WIDTH-1:0]     dout_2,
   output logic signed [DATA_WIDTH-1:0]     dout_3,
   output logic signed [DATA_WIDTH-1:0]     dout_4,
   output logic signed [DATA_WIDTH-1:0]     dout_5,
   output logic signed [DATA_WIDTH-1:0]     dout_6,
   output logic signed [DATA_WIDTH-1:0]     dout_7,
   output logic signed [DATA_WIDTH-1:0]     dout_8,
   output logic signed [DATA_WIDTH-1:0]     dout_9,
   output logic signed [DATA_WIDTH-1:0]     dout_10,
   output logic signed [DATA_WIDTH-1:0]     dout_11,
   output logic signed [DATA_WIDTH-1:0]     dout_12,
   output logic signed [DATA_WIDTH-1:0]     dout_13,
   output logic signed [DATA_WIDTH-1:0]     dout_14,
   output logic signed [DATA_WIDTH-1:0]     dout_15,
   output logic                             sat_flag
);

   localparam int c_lanes = 8;
   localparam int c_sum_w = INTERNAL_WIDTH + 1;
   // Width of the rounded quotient; must exceed DATA_WIDTH for saturation.
   localparam int c_q_w   = c_sum_w - SHIFT;
   localparam logic [c_sum_w-1:0]    c_half = {{(c_sum_w-1){1'b0}}, 1'b1} << (SHIFT-1);
   localparam logic [DATA_WIDTH-1:0] c_max  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] c_min  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic {PH_EVEN = 1'b0, PH_ODD = 1'b1} ph_e;

   logic signed [INTERNAL_WIDTH-1:0] w_a1       [c_lanes];
   logic        [DATA_WIDTH-1:0]     w_sat_val  [c_lanes];
   logic        [c_lanes-1:0]        w_lane_sat;

   logic        [DATA_WIDTH-1:0]     s1_q       [c_lanes];
   logic                             v1_q;
   logic                             sat_q;
   logic        [DATA_WIDTH-1:0]     low_q      [c_lanes];
   logic        [DATA_WIDTH-1:0]     dout_q     [2*c_lanes];
   logic                             dout_valid_q;
   ph_e                              ph_q, ph_d;
   logic                             w_load_low;
   logic                             w_emit;

   assign w_a1[0] = a1_0;
   assign w_a1[1] = a1_1;
   assign w_a1[2] = a1_2;
   assign w_a1[3] = a1_3;
   assign w_a1[4] = a1_4;
   assign w_a1[5] = a1_5;
   assign w_a1[6] = a1_6;
   assign w_a1[7] = a1_7;

   generate
      for (genvar g = 0; g < c_lanes; g++) begin : g_lane
         logic [c_sum_w-1:0]           w_sum;
         logic [c_q_w-1:0]             w_q;
         logic [c_q_w-DATA_WIDTH:0]    w_hi;
         logic                         w_fits;
         // Sign-extend by one bit so adding the half-LSB can never wrap.
         assign w_sum  = {w_a1[g][INTERNAL_WIDTH-1], w_a1[g]} + c_half;
         // Dropping low bits of a two's-complement value is a floor divide.
         assign w_q    = w_sum[c_sum_w-1:SHIFT];
         // Value fits when every bit from the output sign bit up is equal.
         assign w_hi   = w_q[c_q_w-1:DATA_WIDTH-1];
         assign w_fits = (&w_hi) | ~(|w_hi);
         assign w_lane_sat[g] = ~w_fits;
         assign w_sat_val[g]  = w_fits ? w_q[DATA_WIDTH-1:0]
                                       : (w_q[c_q_w-1] ? c_min : c_max);
      end
   endgenerate

   // Stage 1: rounded/saturated word, its valid bit and the sticky flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q  <= 1'b0;
         sat_q <= 1'b0;
         for (int i = 0; i < c_lanes; i++) s1_q[i] <= '0;
      end else begin
         v1_q <= din_valid & ~sync_clr;
         if (din_valid) begin
            for (int i = 0; i < c_lanes; i++) s1_q[i] <= w_sat_val[i];
         end
         if (sync_clr)                       sat_q <= 1'b0;
         else if (din_valid && |w_lane_sat) sat_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ph_q <= PH_EVEN;
      else        ph_q <= ph_d;
   end

   always_comb begin
      ph_d       = ph_q;
      w_load_low = 1'b0;
      w_emit     = 1'b0;
      if (sync_clr) begin
         ph_d = PH_EVEN;
      end else if (v1_q) begin
         if (ph_q == PH_EVEN) begin
            w_load_low = 1'b1;
            ph_d       = PH_ODD;
         end else begin
            w_emit = 1'b1;
            ph_d   = PH_EVEN;
         end
      end
   end

   // Pairing datapath: low buffer and packed output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_valid_q <= 1'b0;
         for (int i = 0; i < c_lanes; i++)   low_q[i]  <= '0;
         for (int i = 0; i < 2*c_lanes; i++) dout_q[i] <= '0;
      end else begin
         dout_valid_q <= w_emit;
         if (w_load_low) begin
            for (int i = 0; i < c_lanes; i++) low_q[i] <= s1_q[i];
         end
         if (w_emit) begin
            for (int i = 0; i < c_lanes; i++) begin
               dout_q[i]         <= low_q[i];
               dout_q[i+c_lanes] <= s1_q[i];
            end
         end
      end
   end

   assign dout_valid = dout_valid_q;
   assign sat_flag   = sat_q;
   assign dout_0     = dout_q[0];
   assign dout_1     = dout_q[1];
   assign dout_2     = dout_q[2];
   assign dout_3     = dout_q[3];
   assign dout_4     = dout_q[4];
   assign dout_5     = dout_q[5];
   assign dout_6     = dout_q[6];
   assign dout_7     = dout_q[7];
   assign dout_8     = dout_q[8];
   assign dout_9     = dout_q[9];
   assign dout_10    = dout_q[10];
   assign dout_11    = dout_q[11];
   assign dout_12    = dout_q[12];
   assign dout_13    = dout_q[13];
   assign dout_14    = dout_q[14];
   assign dout_15    = dout_q[15];

endmodule
`default_nettype wire
